rx_channel_buffer: RTL and testbench



---
 rtl/rx_channel_buffer.sv | 160 ++++++++++++++++
 tb/tb_rx_channel_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_channel_buffer.sv
// rx_channel_buffer: per-channel packet receive queues with commit/rewind and a bus drain window
module rx_channel_buffer #(
    parameter int          NUM_CH       = 4,
    parameter int          DEPTH        = 128,
    parameter int          WORD_W       = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h3000,
    parameter bit          DROP_ON_FULL = 1'b1,
    localparam int         CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_valid,
    input  logic [CW-1:0]     wr_ch,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              wr_abort,
    output logic              wr_ready,
    input  logic [31:0]       bus_addr,
    input  logic              bus_ren,
    input  logic              bus_wen,
    input  logic [31:0]       bus_wdata,
    input  logic [3:0]        bus_strobe,
    output logic [31:0]       bus_rdata,
    output logic              bus_error,
    output logic              bus_stall,
    output logic [NUM_CH-1:0] pkt_avail
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, RESP, COOL} state_t;

    logic [WORD_W-1:0] mem [NUM_CH*DEPTH];
    logic [PW-1:0]     rd_ptr [NUM_CH];
    logic [PW-1:0]     commit_ptr [NUM_CH];
    logic [PW-1:0]     spec_ptr [NUM_CH];
    logic [PW-1:0]     count [NUM_CH];
    logic [7:0]        pkt_count [NUM_CH];
    logic [NUM_CH-1:0] overflow, poison, full, wr_sel, bus_sel, rd_sel;
    state_t            state, state_nx;
    logic [CW-1:0]     rd_ch, a_ch;
    logic [WORD_W-1:0] rdata_q;
    logic [31:0]       off, status;
    logic [1:0]        a_reg;
    logic ren, wen, idle, in_range, rd_data, rd_stat, wr_ctrl;
    logic flush, clr_ovf, ack, accept, store, dropped, rewind, commit;
    logic unused_bits;

    assign unused_bits = ^{bus_wdata[31:3], bus_strobe[3:1]};

    // Per-channel occupancy and channel-select decode
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            count[c]   = commit_ptr[c] - rd_ptr[c];
            full[c]    = (spec_ptr[c] - rd_ptr[c]) == PW'(DEPTH);
            wr_sel[c]  = wr_ch == CW'(c);
            bus_sel[c] = a_ch == CW'(c);
            rd_sel[c]  = rd_ch == CW'(c);
        end
    end

    // Bus request decode; requests are ignored while reset is asserted so outputs sit at reset values
    always_comb begin
        ren      = bus_ren & n_rst;
        wen      = bus_wen & n_rst;
        idle     = state == IDLE;
        off      = bus_addr - BASE_ADDR;
        in_range = (bus_addr >= BASE_ADDR) && (off < 32'(16 * NUM_CH));
        a_ch     = off[4 +: CW];
        a_reg    = off[3:2];
        rd_data  = idle & ren & in_range & (a_reg == 2'd0) & (count[a_ch] != '0);
        rd_stat  = idle & ren & in_range & (a_reg == 2'd1);
        wr_ctrl  = idle & !ren & wen & in_range & (a_reg == 2'd2) & bus_strobe[0];
        flush    = wr_ctrl & bus_wdata[0];
        clr_ovf  = wr_ctrl & bus_wdata[1];
        ack      = wr_ctrl & bus_wdata[2];
        status   = {6'd0, spec_ptr[a_ch] != commit_ptr[a_ch], overflow[a_ch], pkt_count[a_ch], 16'(count[a_ch])};
    end

    // Write-side decisions; a flush of the target channel swallows the word, full is judged pre-pop
    always_comb begin
        wr_ready = DROP_ON_FULL ? 1'b1 : !full[wr_ch];
        accept   = wr_valid & wr_ready & !wr_abort & !(flush & bus_sel[wr_ch]);
        store    = accept & !full[wr_ch];
        dropped  = accept & full[wr_ch];
        rewind   = (wr_abort & !(flush & bus_sel[wr_ch])) | (accept & wr_last & (poison[wr_ch] | full[wr_ch]));
        commit   = store & wr_last & !poison[wr_ch];
    end

    // Channel pointers, packet counts and flags; flush is last so it overrides everything else
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr[c]     <= '0;
                commit_ptr[c] <= '0;
                spec_ptr[c]   <= '0;
                pkt_count[c]  <= '0;
            end
            overflow  <= '0;
            poison    <= '0;
            pkt_avail <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                pkt_avail[c] <= pkt_count[c] != 8'd0;
                if (state == RESP && rd_sel[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
                if (wr_sel[c] && rewind) begin
                    spec_ptr[c] <= commit_ptr[c];
                    poison[c]   <= 1'b0;
                end else if (wr_sel[c] && store) begin
                    spec_ptr[c] <= spec_ptr[c] + 1'b1;
                end else if (wr_sel[c] && dropped) begin
                    poison[c] <= 1'b1;
                end
                if (wr_sel[c] && commit) commit_ptr[c] <= spec_ptr[c] + 1'b1;
                if (clr_ovf && bus_sel[c]) overflow[c] <= 1'b0;
                if (wr_sel[c] && dropped) overflow[c] <= 1'b1;
                if (wr_sel[c] && commit && !(ack && bus_sel[c]) && pkt_count[c] != 8'hFF)
                    pkt_count[c] <= pkt_count[c] + 1'b1;
                else if (ack && bus_sel[c] && !(wr_sel[c] && commit) && pkt_count[c] != 8'd0)
                    pkt_count[c] <= pkt_count[c] - 1'b1;
                if (flush && bus_sel[c]) begin
                    rd_ptr[c]     <= '0;
                    commit_ptr[c] <= '0;
                    spec_ptr[c]   <= '0;
                    pkt_count[c]  <= '0;
                    poison[c]     <= spec_ptr[c] != commit_ptr[c];
                end
            end
        end
    end

    // Word storage and the DATA-read latch
    always_ff @(posedge clk) begin
        if (store) mem[{wr_ch, spec_ptr[wr_ch][AW-1:0]}] <= wr_data;
        if (rd_data) rdata_q <= mem[{a_ch, rd_ptr[a_ch][AW-1:0]}];
    end

    // Read controller state register, remembers which channel to pop
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            rd_ch <= '0;
        end else begin
            state <= state_nx;
            if (rd_data) rd_ch <= a_ch;
        end
    end

    // Next state: stall cycle, response cycle, then one idle cycle so a held request never double-pops
    always_comb begin
        state_nx = (state == IDLE) ? (rd_data ? RESP : IDLE) : (state == RESP) ? COOL : IDLE;
    end

    // Bus outputs
    always_comb begin
        bus_stall = rd_data;
        bus_rdata = (state == RESP) ? 32'(rdata_q) : rd_stat ? status : 32'hBAD1BAD1;
        bus_error = idle & ((ren & !rd_data & !rd_stat) | (!ren & wen & !(in_range & (a_reg == 2'd2))));
    end
endmodule

// File: tb/tb_rx_channel_buffer.sv
// tb_rx_channel_buffer: directed scenarios for the multi-channel RX buffer (drop and backpressure builds)
module tb_rx_channel_buffer;
    logic        clk = 1'b0, n_rst = 1'b0;
    logic        wr_valid = 1'b0, wr_last = 1'b0, wr_abort = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [31:0] wr_data = '0, bus_addr = '0, bus_wdata = '0;
    logic        bus_ren = 1'b0, bus_wen = 1'b0;
    logic [3:0]  bus_strobe = '0;
    logic        wr_ready, bus_error, bus_stall, wr_ready_bp, error_bp, stall_bp;
    logic [31:0] bus_rdata, rdata_bp;
    logic [3:0]  pkt_avail, avail_bp;
    logic [31:0] d;
    logic        s1, s2, e;
    int          n_chk = 0, n_fail = 0;

    rx_channel_buffer #(.DEPTH(8), .DROP_ON_FULL(1'b1)) dut (
        .clk(clk), .n_rst(n_rst), .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_data(wr_data),
        .wr_last(wr_last), .wr_abort(wr_abort), .wr_ready(wr_ready), .bus_addr(bus_addr),
        .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
        .bus_rdata(bus_rdata), .bus_error(bus_error), .bus_stall(bus_stall), .pkt_avail(pkt_avail));

    rx_channel_buffer #(.DEPTH(8), .DROP_ON_FULL(1'b0)) dut_bp (
        .clk(clk), .n_rst(n_rst), .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_data(wr_data),
        .wr_last(wr_last), .wr_abort(wr_abort), .wr_ready(wr_ready_bp), .bus_addr(bus_addr),
        .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
        .bus_rdata(rdata_bp), .bus_error(error_bp), .bus_stall(stall_bp), .pkt_avail(avail_bp));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] w, input logic last);
        wr_valid = 1'b1; wr_ch = ch; wr_data = w; wr_last = last;
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    // Read request: returns first-cycle stall/error, second-cycle stall, and the data seen
    task automatic bus_rd(input logic [31:0] a, output logic [31:0] rd, output logic st1, output logic st2, output logic er);
        bus_addr = a; bus_ren = 1'b1;
        #1;
        st1 = bus_stall; er = bus_error; rd = bus_rdata; st2 = 1'b0;
        if (st1) begin
            @(posedge clk);
            #2;
            st2 = bus_stall; rd = bus_rdata; bus_ren = 1'b0;
            tick();
            tick();
        end else begin
            bus_ren = 1'b0;
            tick();
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s, output logic er);
        bus_addr = a; bus_wdata = w; bus_strobe = s; bus_wen = 1'b1;
        #1;
        er = bus_error;
        tick();
        bus_wen = 1'b0;
    endtask

    task automatic test_reset;
        n_chk++; if ({wr_ready, wr_ready_bp, bus_error, bus_stall, pkt_avail} !== 8'b1100_0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 11000000", {wr_ready, wr_ready_bp, bus_error, bus_stall, pkt_avail}); end
        n_chk++; if (bus_rdata !== 32'hBAD1BAD1) begin n_fail++; $display("FAIL reset_rdata: got %h expected bad1bad1", bus_rdata); end
    endtask

    task automatic test_basic;
        push(2, 32'hA0, 0); push(2, 32'hA1, 0); push(2, 32'hA2, 1);
        bus_rd(32'h3024, d, s1, s2, e);
        n_chk++; if (d !== 32'h0001_0003) begin n_fail++; $display("FAIL basic_status: got %h expected 00010003", d); end
        n_chk++; if (pkt_avail !== 4'b0100) begin n_fail++; $display("FAIL basic_avail: got %b expected 0100", pkt_avail); end
        for (int i = 0; i < 3; i++) begin
            bus_rd(32'h3020, d, s1, s2, e);
            n_chk++; if ({s1, s2, e} !== 3'b100) begin n_fail++; $display("FAIL basic_stall%0d: got %b expected 100", i, {s1, s2, e}); end
            n_chk++; if (d !== 32'(32'hA0 + i)) begin n_fail++; $display("FAIL basic_data%0d: got %h expected %h", i, d, 32'(32'hA0 + i)); end
        end
        bus_rd(32'h3024, d, s1, s2, e);
        n_chk++; if (d !== 32'h0001_0000) begin n_fail++; $display("FAIL basic_drained: got %h expected 00010000", d); end
        bus_wr(32'h3028, 32'h4, 4'h1, e);
        tick();
        n_chk++; if (pkt_avail !== 4'b0000) begin n_fail++; $display("FAIL basic_ack_avail: got %b expected 0000", pkt_avail); end
    endtask

    task automatic test_abort;
        push(1, 32'hB0, 0); push(1, 32'hB1, 0);
        bus_rd(32'h3014, d, s1, s2, e);
        n_chk++; if (d !== 32'h0200_0000) begin n_fail++; $display("FAIL abort_inflight: got %h expected 02000000", d); end
        wr_abort = 1'b1; wr_valid = 1'b1; wr_ch = 1; wr_data = 32'hBB;
        tick();
        wr_abort = 1'b0; wr_valid = 1'b0;
        bus_rd(32'h3014, d, s1, s2, e);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL abort_status: got %h expected 00000000", d); end
        push(1, 32'hC0, 0); push(1, 32'hC1, 1);
        bus_rd(32'h3010, d, s1, s2, e);
        n_chk++; if (d !== 32'hC0) begin n_fail++; $display("FAIL abort_data0: got %h expected c0", d); end
        bus_rd(32'h3010, d, s1, s2, e);
        n_chk++; if (d !== 32'hC1) begin n_fail++; $display("FAIL abort_data1: got %h expected c1", d); end
        bus_wr(32'h3018, 32'h4, 4'h1, e);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 10; i++) push(0, 32'(32'hD00 + i), i == 9);
        wr_ch = 0;
        #1;
        n_chk++; if ({wr_ready, wr_ready_bp} !== 2'b10) begin n_fail++; $display("FAIL ovf_ready: got %b expected 10", {wr_ready, wr_ready_bp}); end
        bus_rd(32'h3004, d, s1, s2, e);
        n_chk++; if (d !== 32'h0100_0000) begin n_fail++; $display("FAIL ovf_status: got %h expected 01000000", d); end
        bus_wr(32'h3008, 32'h3, 4'h1, e);
        n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL ovf_ctrl_err: got %b expected 0", e); end
        bus_rd(32'h3004, d, s1, s2, e);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL ovf_cleared: got %h expected 00000000", d); end
        n_chk++; if (wr_ready_bp !== 1'b1) begin n_fail++; $display("FAIL ovf_bp_flushed: got %b expected 1", wr_ready_bp); end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 8; i++) push(3, 32'(32'hE00 + i), i == 7);
        n_chk++; if ({wr_ready, wr_ready_bp} !== 2'b10) begin n_fail++; $display("FAIL bp_full: got %b expected 10", {wr_ready, wr_ready_bp}); end
        bus_rd(32'h3030, d, s1, s2, e);
        n_chk++; if (d !== 32'hE00) begin n_fail++; $display("FAIL bp_first: got %h expected e00", d); end
        n_chk++; if (wr_ready_bp !== 1'b1) begin n_fail++; $display("FAIL bp_after_pop: got %b expected 1", wr_ready_bp); end
        for (int i = 1; i < 8; i++) begin
            bus_rd(32'h3030, d, s1, s2, e);
            n_chk++; if (d !== 32'(32'hE00 + i)) begin n_fail++; $display("FAIL bp_data%0d: got %h expected %h", i, d, 32'(32'hE00 + i)); end
        end
        bus_wr(32'h3038, 32'h4, 4'h1, e);
        bus_rd(32'h3034, d, s1, s2, e);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL bp_status: got %h expected 00000000", d); end
    endtask

    task automatic test_interleave;
        push(0, 32'hF0, 0); push(3, 32'hF30, 0); push(0, 32'hF1, 1); push(3, 32'hF31, 0); push(3, 32'hF32, 1);
        bus_rd(32'h3004, d, s1, s2, e);
        n_chk++; if (d !== 32'h0001_0002) begin n_fail++; $display("FAIL il_status0: got %h expected 00010002", d); end
        bus_rd(32'h3034, d, s1, s2, e);
        n_chk++; if (d !== 32'h0001_0003) begin n_fail++; $display("FAIL il_status3: got %h expected 00010003", d); end
        bus_addr = 32'h3000; bus_ren = 1'b1;
        #1;
        n_chk++; if (bus_stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall: got %b expected 1", bus_stall); end
        tick();
        n_chk++; if ({bus_stall, bus_rdata} !== {1'b0, 32'hF0}) begin n_fail++; $display("FAIL hold_data: got %b/%h expected 0/f0", bus_stall, bus_rdata); end
        tick();
        n_chk++; if ({bus_stall, bus_error} !== 2'b00) begin n_fail++; $display("FAIL hold_idle: got %b expected 00", {bus_stall, bus_error}); end
        bus_ren = 1'b0;
        tick();
        bus_rd(32'h3004, d, s1, s2, e);
        n_chk++; if (d !== 32'h0001_0001) begin n_fail++; $display("FAIL hold_single_pop: got %h expected 00010001", d); end
        bus_rd(32'h3000, d, s1, s2, e);
        n_chk++; if (d !== 32'hF1) begin n_fail++; $display("FAIL il_ch0: got %h expected f1", d); end
        for (int i = 0; i < 3; i++) begin
            bus_rd(32'h3030, d, s1, s2, e);
            n_chk++; if (d !== 32'(32'hF30 + i)) begin n_fail++; $display("FAIL il_ch3_%0d: got %h expected %h", i, d, 32'(32'hF30 + i)); end
        end
        bus_wr(32'h3008, 32'h4, 4'h1, e);
        bus_wr(32'h3038, 32'h4, 4'h1, e);
    endtask

    task automatic test_errors;
        bus_rd(32'h3010, d, s1, s2, e);
        n_chk++; if ({s1, e, d} !== {2'b01, 32'hBAD1BAD1}) begin n_fail++; $display("FAIL err_empty: got %b%b/%h expected 01/bad1bad1", s1, e, d); end
        bus_wr(32'h3014, 32'h0, 4'hF, e);
        n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_wr_status: got %b expected 1", e); end
        bus_wr(32'h3000, 32'h0, 4'hF, e);
        n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_wr_data: got %b expected 1", e); end
        bus_rd(32'h3040, d, s1, s2, e);
        n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_above: got %b expected 1", e); end
        bus_rd(32'h2FFC, d, s1, s2, e);
        n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_below: got %b expected 1", e); end
        bus_rd(32'h3018, d, s1, s2, e);
        n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_rd_ctrl: got %b expected 1", e); end
        bus_rd(32'h301C, d, s1, s2, e);
        n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_reserved: got %b expected 1", e); end
    endtask

    task automatic test_flush;
        push(1, 32'h51, 0); push(1, 32'h52, 0);
        bus_wr(32'h3018, 32'h1, 4'h2, e);
        bus_rd(32'h3014, d, s1, s2, e);
        n_chk++; if (d !== 32'h0200_0000) begin n_fail++; $display("FAIL flush_nostrobe: got %h expected 02000000", d); end
        bus_wr(32'h3018, 32'h1, 4'h1, e);
        bus_rd(32'h3014, d, s1, s2, e);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL flush_status: got %h expected 00000000", d); end
        push(1, 32'h53, 1);
        tick();
        bus_rd(32'h3014, d, s1, s2, e);
        n_chk++; if ({d, pkt_avail} !== {32'h0, 4'b0000}) begin n_fail++; $display("FAIL flush_discard: got %h/%b expected 00000000/0000", d, pkt_avail); end
        push(1, 32'h54, 1);
        bus_rd(32'h3014, d, s1, s2, e);
        n_chk++; if (d !== 32'h0001_0001) begin n_fail++; $display("FAIL flush_next: got %h expected 00010001", d); end
        bus_rd(32'h3010, d, s1, s2, e);
        n_chk++; if (d !== 32'h54) begin n_fail++; $display("FAIL flush_data: got %h expected 54", d); end
    endtask

    task automatic test_reset_mid_read;
        push(2, 32'h77, 1);
        tick();
        n_chk++; if (pkt_avail[2] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_avail: got %b expected 1", pkt_avail[2]); end
        bus_addr = 32'h3020; bus_ren = 1'b1;
        #1;
        n_chk++; if (bus_stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %b expected 1", bus_stall); end
        n_rst = 1'b0;
        #1;
        n_chk++; if ({bus_stall, bus_error, wr_ready, pkt_avail} !== 7'b0010000) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 0010000", {bus_stall, bus_error, wr_ready, pkt_avail}); end
        n_chk++; if (bus_rdata !== 32'hBAD1BAD1) begin n_fail++; $display("FAIL rst_mid_rdata: got %h expected bad1bad1", bus_rdata); end
        bus_ren = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        bus_rd(32'h3024, d, s1, s2, e);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h expected 00000000", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_abort();
        test_overflow();
        test_backpressure();
        test_interleave();
        test_errors();
        test_flush();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
